// File: rtl/sap_pkg.sv
// Shared constants for the SAP-1 style CPU: control-word bit positions and
// default datapath widths used by the datapath and its RAM.
package sap_pkg;

  localparam int CW_W = 15;

  localparam int CW_HLT = 14;
  localparam int CW_MI  = 13;
  localparam int CW_RI  = 12;
  localparam int CW_RO  = 11;
  localparam int CW_IO  = 10;
  localparam int CW_II  = 9;
  localparam int CW_AI  = 8;
  localparam int CW_AO  = 7;
  localparam int CW_EO  = 6;
  localparam int CW_SU  = 5;
  localparam int CW_BI  = 4;
  localparam int CW_OI  = 3;
  localparam int CW_CE  = 2;
  localparam int CW_CO  = 1;
  localparam int CW_J   = 0;

  localparam int SAP_DATA_W = 8;
  localparam int SAP_ADDR_W = 4;

  localparam int NUM_DRIVERS = 5;

  // True when more than one bus driver is enabled at once.
  function automatic logic multi_hot(input logic [NUM_DRIVERS-1:0] v);
    return (v & (v - NUM_DRIVERS'(1))) != '0;
  endfunction

endpackage

// File: rtl/sap_ram16x8.sv
// Program/data RAM: one synchronous write port, one combinational read port.
// Write-source arbitration (external programming vs. RI) lives in the parent.
module sap_ram16x8
  import sap_pkg::*;
#(
  parameter int DATA_W = SAP_DATA_W,
  parameter int ADDR_W = SAP_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: storage arrays carry no reset; clearing them would force flops
  // instead of RAM and the program image must survive a CPU reset anyway.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sap_datapath.sv
// Execution datapath of the 8-bit CPU: shared bus, PC, MAR, RAM, IR, A/B,
// add/sub ALU with flags and output register, steered by the control word.
module sap_datapath
  import sap_pkg::*;
#(
  parameter int DATA_W = SAP_DATA_W,
  parameter int ADDR_W = SAP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CW_W-1:0]   ctrl,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        opcode,
  output logic [DATA_W-1:0] out_value,
  output logic              out_valid,
  output logic              flag_c,
  output logic              flag_z,
  output logic              halted,
  output logic              bus_err
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [DATA_W-1:0] out_reg;

  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_r;
  logic              alu_c;
  logic              live;
  logic              multi_drv;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  logic [NUM_DRIVERS-1:0] drv;

  // Once halted, the control word is ignored entirely; only prog_we remains.
  assign live = ~halted;

  assign drv = {ctrl[CW_RO], ctrl[CW_IO], ctrl[CW_AO], ctrl[CW_EO], ctrl[CW_CO]};
  assign multi_drv = multi_hot(drv);

  // Subtract as A + ~B + 1 so carry-out doubles as "no borrow".
  always_comb begin
    alu_b = ctrl[CW_SU] ? ~b_reg : b_reg;
    {alu_c, alu_r} = {1'b0, a_reg} + {1'b0, alu_b} + (DATA_W + 1)'(ctrl[CW_SU]);
  end

  // NOTE: every always_comb output gets a default before any condition so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    bus = '0;
    if (ctrl[CW_RO]) bus = bus | ram_rdata;
    if (ctrl[CW_IO]) bus = bus | {{(DATA_W - 4){1'b0}}, ir[3:0]};
    if (ctrl[CW_AO]) bus = bus | a_reg;
    if (ctrl[CW_EO]) bus = bus | alu_r;
    if (ctrl[CW_CO]) bus = bus | {{(DATA_W - ADDR_W){1'b0}}, pc};
  end

  // External programming owns the write port whenever it is active.
  always_comb begin
    ram_we    = prog_we | (live & ctrl[CW_RI]);
    ram_waddr = prog_we ? prog_addr : mar;
    ram_wdata = prog_we ? prog_data : bus;
  end

  sap_ram16x8 #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(mar),
    .rdata(ram_rdata)
  );

  // NOTE: state registers use non-blocking assignments so every load in this
  // block samples the pre-edge bus and register values, e.g. AI with AO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= '0;
      mar       <= '0;
      ir        <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      out_reg   <= '0;
      out_valid <= 1'b0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      halted    <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      out_valid <= live & ctrl[CW_OI];
      if (live) begin
        if (ctrl[CW_MI]) mar     <= bus[ADDR_W-1:0];
        if (ctrl[CW_II]) ir      <= bus;
        if (ctrl[CW_AI]) a_reg   <= bus;
        if (ctrl[CW_BI]) b_reg   <= bus;
        if (ctrl[CW_OI]) out_reg <= bus;

        if (ctrl[CW_J])       pc <= bus[ADDR_W-1:0];
        else if (ctrl[CW_CE]) pc <= pc + ADDR_W'(1);

        if (ctrl[CW_EO]) begin
          flag_c <= alu_c;
          flag_z <= (alu_r == '0);
        end

        if (multi_drv)    bus_err <= 1'b1;
        if (ctrl[CW_HLT]) halted  <= 1'b1;
      end
    end
  end

  assign opcode    = ir[DATA_W-1 -: 4];
  assign out_value = out_reg;

endmodule

// File: tb/tb_sap_datapath.sv
// Self-checking bench for sap_datapath: directed scenarios plus randomized
// control words, all compared against a behavioural CPU-datapath model.
module tb_sap_datapath;

  localparam logic [14:0] K_HLT = 15'h4000;
  localparam logic [14:0] K_MI  = 15'h2000;
  localparam logic [14:0] K_RI  = 15'h1000;
  localparam logic [14:0] K_RO  = 15'h0800;
  localparam logic [14:0] K_IO  = 15'h0400;
  localparam logic [14:0] K_II  = 15'h0200;
  localparam logic [14:0] K_AI  = 15'h0100;
  localparam logic [14:0] K_AO  = 15'h0080;
  localparam logic [14:0] K_EO  = 15'h0040;
  localparam logic [14:0] K_SU  = 15'h0020;
  localparam logic [14:0] K_BI  = 15'h0010;
  localparam logic [14:0] K_OI  = 15'h0008;
  localparam logic [14:0] K_CE  = 15'h0004;
  localparam logic [14:0] K_CO  = 15'h0002;
  localparam logic [14:0] K_J   = 15'h0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] ctrl;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [3:0]  opcode;
  logic [7:0]  out_value;
  logic        out_valid;
  logic        flag_c;
  logic        flag_z;
  logic        halted;
  logic        bus_err;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] m_ram [16];
  logic [7:0] m_a, m_b, m_ir, m_out;
  logic [3:0] m_pc, m_mar;
  logic       m_ov, m_c, m_z, m_h, m_e;

  always #5 clk = ~clk;

  sap_datapath #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .ctrl     (ctrl),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .opcode   (opcode),
    .out_value(out_value),
    .out_valid(out_valid),
    .flag_c   (flag_c),
    .flag_z   (flag_z),
    .halted   (halted),
    .bus_err  (bus_err)
  );

  wire [16:0] dut_vec = {opcode, out_value, out_valid, flag_c, flag_z, halted, bus_err};

  function automatic logic [16:0] model_vec();
    return {m_ir[7:4], m_out, m_ov, m_c, m_z, m_h, m_e};
  endfunction

  task automatic model_reset();
    m_a = 0; m_b = 0; m_ir = 0; m_out = 0; m_pc = 0; m_mar = 0;
    m_ov = 0; m_c = 0; m_z = 0; m_h = 0; m_e = 0;
  endtask

  // One clock of CPU behaviour, described from the datapath rules.
  task automatic model_step(input logic [14:0] cw, input logic pwe,
                            input logic [3:0] pa, input logic [7:0] pd);
    logic [7:0] bus;
    logic [8:0] sum;
    int         n;
    bus = 8'h00;
    n = 0;
    if (cw[14]) begin end
    if (cw & K_SU) sum = {1'b0, m_a} + {1'b0, ~m_b} + 9'd1;
    else           sum = {1'b0, m_a} + {1'b0, m_b};
    if (cw & K_RO) begin bus |= m_ram[m_mar];     n++; end
    if (cw & K_IO) begin bus |= {4'h0, m_ir[3:0]}; n++; end
    if (cw & K_AO) begin bus |= m_a;              n++; end
    if (cw & K_EO) begin bus |= sum[7:0];         n++; end
    if (cw & K_CO) begin bus |= {4'h0, m_pc};     n++; end
    if (m_h) begin
      m_ov = 0;
    end else begin
      if ((cw & K_RI) && !pwe) m_ram[m_mar] = bus;
      if (cw & K_MI) m_mar = bus[3:0];
      if (cw & K_II) m_ir  = bus;
      if (cw & K_AI) m_a   = bus;
      if (cw & K_BI) m_b   = bus;
      if (cw & K_OI) m_out = bus;
      m_ov = (cw & K_OI) != 0;
      if (cw & K_J)       m_pc = bus[3:0];
      else if (cw & K_CE) m_pc = m_pc + 4'd1;
      if (cw & K_EO) begin
        m_c = sum[8];
        m_z = (sum[7:0] == 8'h00);
      end
      if (n > 1) m_e = 1;
      if (cw & K_HLT) m_h = 1;
    end
    if (pwe) m_ram[pa] = pd;
  endtask

  // Drive one cycle on the falling edge, let it clock, settle, then idle inputs.
  task automatic step(input logic [14:0] cw, input logic pwe = 1'b0,
                      input logic [3:0] pa = 4'h0, input logic [7:0] pd = 8'h00);
    @(negedge clk);
    ctrl = cw; prog_we = pwe; prog_addr = pa; prog_data = pd;
    model_step(cw, pwe, pa, pd);
    @(posedge clk);
    #1;
    ctrl = '0; prog_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic load_a(input logic [7:0] v);
    step('0, 1'b1, m_mar, v);
    step(K_RO | K_AI);
  endtask

  task automatic load_b(input logic [7:0] v);
    step('0, 1'b1, m_mar, v);
    step(K_RO | K_BI);
  endtask

  task automatic set_pc(input logic [3:0] v);
    step('0, 1'b1, m_mar, {4'h0, v});
    step(K_RO | K_J);
  endtask

  task automatic test_reset();
    n_chk++;
    if (dut_vec !== 17'h0) begin
      $display("FAIL reset_init: got %h want %h", dut_vec, 17'h0); n_err++;
    end
    load_a(8'h55);
    set_pc(4'd7);
    step(K_AO | K_OI);
    n_chk++;
    if (out_value !== 8'h55 || out_valid !== 1'b1) begin
      $display("FAIL reset_pre: got out=%h v=%b want 55/1", out_value, out_valid); n_err++;
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (dut_vec !== 17'h0) begin
      $display("FAIL reset_mid: got %h want %h", dut_vec, 17'h0); n_err++;
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(K_CO | K_OI);
    n_chk++;
    if (out_value !== 8'h00 || halted !== 1'b0) begin
      $display("FAIL reset_pc: got pc=%h h=%b want 00/0", out_value, halted); n_err++;
    end
  endtask

  task automatic test_fetch();
    do_reset();
    step('0, 1'b1, 4'h0, 8'h1E);
    step(K_CO | K_MI);
    step(K_RO | K_II | K_CE);
    n_chk++;
    if (opcode !== 4'h1) begin
      $display("FAIL fetch_opcode: got %h want 1", opcode); n_err++;
    end
    step(K_CO | K_OI);
    n_chk++;
    if (out_value !== 8'h01) begin
      $display("FAIL fetch_pc: got %h want 01", out_value); n_err++;
    end
    step(K_IO | K_OI);
    n_chk++;
    if (out_value !== 8'h0E) begin
      $display("FAIL fetch_ir_lo: got %h want 0e", out_value); n_err++;
    end
  endtask

  task automatic test_alu();
    do_reset();
    load_a(8'hF0);
    load_b(8'h20);
    step(K_EO | K_AI);
    step(K_AO | K_OI);
    n_chk++;
    if ({out_value, flag_c, flag_z} !== {8'h10, 1'b1, 1'b0}) begin
      $display("FAIL alu_add: got %h c=%b z=%b want 10 c=1 z=0", out_value, flag_c, flag_z); n_err++;
    end
    load_b(8'h10);
    step(K_EO | K_SU | K_AI);
    step(K_AO | K_OI);
    n_chk++;
    if ({out_value, flag_c, flag_z} !== {8'h00, 1'b1, 1'b1}) begin
      $display("FAIL alu_sub_zero: got %h c=%b z=%b want 00 c=1 z=1", out_value, flag_c, flag_z); n_err++;
    end
    load_a(8'h01);
    load_b(8'h02);
    step(K_EO | K_SU | K_AI);
    step(K_AO | K_OI);
    n_chk++;
    if ({out_value, flag_c, flag_z} !== {8'hFF, 1'b0, 1'b0}) begin
      $display("FAIL alu_borrow: got %h c=%b z=%b want ff c=0 z=0", out_value, flag_c, flag_z); n_err++;
    end
    n_chk++;
    if (dut_vec !== model_vec()) begin
      $display("FAIL alu_model: got %h want %h", dut_vec, model_vec()); n_err++;
    end
  endtask

  task automatic test_pc();
    do_reset();
    set_pc(4'd15);
    step(K_CE);
    step(K_CO | K_OI);
    n_chk++;
    if (out_value !== 8'h00) begin
      $display("FAIL pc_wrap: got %h want 00", out_value); n_err++;
    end
    step('0, 1'b1, m_mar, 8'h09);
    step(K_RO | K_CE | K_J);
    step(K_CO | K_OI);
    n_chk++;
    if (out_value !== 8'h09) begin
      $display("FAIL pc_jump_prio: got %h want 09", out_value); n_err++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    load_a(8'h3C);
    step(K_AO | K_OI);
    step(K_AO | K_OI | K_CE);
    n_chk++;
    if (out_valid !== 1'b1 || out_value !== 8'h3C) begin
      $display("FAIL b2b_valid: got v=%b out=%h want 1/3c", out_valid, out_value); n_err++;
    end
    step('0);
    n_chk++;
    if (out_valid !== 1'b0) begin
      $display("FAIL b2b_drop: got %b want 0", out_valid); n_err++;
    end
  endtask

  task automatic test_output_halt();
    do_reset();
    load_a(8'h2A);
    step(K_AO | K_OI);
    n_chk++;
    if (out_value !== 8'h2A || out_valid !== 1'b1) begin
      $display("FAIL out_load: got %h v=%b want 2a/1", out_value, out_valid); n_err++;
    end
    step(K_HLT);
    n_chk++;
    if (halted !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL halt_set: got h=%b v=%b want 1/0", halted, out_valid); n_err++;
    end
    step(K_CE | K_AI | K_EO | K_OI);
    step(K_CE | K_AI | K_EO | K_OI, 1'b1, 4'd3, 8'h77);
    n_chk++;
    if ({out_value, out_valid, flag_c, flag_z, halted, bus_err} !== {8'h2A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      $display("FAIL halt_freeze: got %h want %h", dut_vec, model_vec()); n_err++;
    end
    do_reset();
    step(K_CE); step(K_CE); step(K_CE);
    step(K_CO | K_MI);
    step(K_RO | K_OI);
    n_chk++;
    if (out_value !== 8'h77) begin
      $display("FAIL halt_prog: got %h want 77", out_value); n_err++;
    end
  endtask

  task automatic test_conflict();
    do_reset();
    load_a(8'h0F);
    step('0, 1'b1, m_mar, 8'hF0);
    step(K_AO | K_RO | K_AI);
    n_chk++;
    if (bus_err !== 1'b1) begin
      $display("FAIL conflict_err: got %b want 1", bus_err); n_err++;
    end
    step('0); step(K_CE);
    step(K_AO | K_OI);
    n_chk++;
    if (out_value !== 8'hFF || bus_err !== 1'b1) begin
      $display("FAIL conflict_or: got %h err=%b want ff/1", out_value, bus_err); n_err++;
    end
    // RI and prog_we together: the external write wins.
    step(K_AO | K_RI, 1'b1, m_mar, 8'h5A);
    step(K_RO | K_OI);
    n_chk++;
    if (out_value !== 8'h5A) begin
      $display("FAIL prog_over_ri: got %h want 5a", out_value); n_err++;
    end
    do_reset();
    n_chk++;
    if (bus_err !== 1'b0) begin
      $display("FAIL conflict_clear: got %b want 0", bus_err); n_err++;
    end
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      step(15'($urandom) & ~K_HLT, ($urandom_range(0, 3) == 0),
           4'($urandom), 8'($urandom));
      n_chk++;
      if (dut_vec !== model_vec()) begin
        n_err++;
        if (bad < 5) $display("FAIL random_%0d: got %h want %h", i, dut_vec, model_vec());
        bad++;
      end
    end
    step(K_HLT | (15'($urandom) & 15'h3FFF));
    for (int i = 0; i < 20; i++) begin
      step(15'($urandom), $urandom_range(0, 1) == 1, 4'($urandom), 8'($urandom));
      n_chk++;
      if (dut_vec !== model_vec()) begin
        n_err++;
        if (bad < 5) $display("FAIL random_halt_%0d: got %h want %h", i, dut_vec, model_vec());
        bad++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; ctrl = '0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    model_reset();
    for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) step('0, 1'b1, 4'(i), 8'($urandom));
    test_reset();
    test_fetch();
    test_alu();
    test_pc();
    test_back_to_back();
    test_output_halt();
    test_conflict();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
